// File: rtl/sys_defs.sv
// Shared sizing constants for the rename free list.
package sys_defs;

  localparam int PR_NUM   = 64;                  // physical registers
  localparam int AR_NUM   = 32;                  // architectural registers
  localparam int PR_W     = 7;                   // physical tag width
  localparam int FL_DEPTH = PR_NUM - AR_NUM;     // free list entries
  localparam int FL_PTR_W = $clog2(FL_DEPTH);    // head/tail pointer width
  localparam int FL_CNT_W = FL_PTR_W + 1;        // occupancy 0..FL_DEPTH
  localparam int SS_WIDTH = 2;                   // dispatch/retire width

endpackage

// File: rtl/fl_ptr_inc.sv
// Modulo-FL_DEPTH pointer adder: ptr_o = (ptr_i + inc_i) mod FL_DEPTH, inc_i in 0..2.
module fl_ptr_inc
  import sys_defs::*;
(
  input  logic [FL_PTR_W-1:0] ptr_i,
  input  logic [1:0]          inc_i,
  output logic [FL_PTR_W-1:0] ptr_o
);

  logic [FL_PTR_W:0] sum;

  // One-step wrap is enough because ptr_i < FL_DEPTH and inc_i <= 2.
  always_comb begin
    sum = {1'b0, ptr_i} + {{(FL_PTR_W-1){1'b0}}, inc_i};
    if (sum >= (FL_PTR_W+1)'(FL_DEPTH)) begin
      ptr_o = sum[FL_PTR_W-1:0] - FL_PTR_W'(FL_DEPTH);
    end else begin
      ptr_o = sum[FL_PTR_W-1:0];
    end
  end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: 2-wide circular FIFO of free tags.
// Retired T_old tags are enqueued from the ROB; dispatch reads the two head
// tags and reports how many it consumed. Outputs depend on registered state only.
// Optional build macro FL_CHECK_EN adds a sticky protocol-error flag (fl_err);
// without it fl_err is tied low. Clamp/drop behaviour is the same in both builds.
module free_list
  import sys_defs::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [PR_W-1:0] fl_retire_tag_a,
  input  logic [PR_W-1:0] fl_retire_tag_b,
  input  logic [1:0]      fl_retire_num,
  input  logic [1:0]      rs_mt_fl_dispatch_num,
  output logic [PR_W-1:0] fl_pr0,
  output logic [PR_W-1:0] fl_pr1,
  output logic [1:0]      fl_avail,
  output logic            fl_err
);

  logic [PR_W-1:0]     mem_q [FL_DEPTH];
  logic [FL_PTR_W-1:0] head_q, head_d, head_p1;
  logic [FL_PTR_W-1:0] tail_q, tail_d, tail_p1;
  logic [FL_CNT_W-1:0] count_q, count_d;
  logic [1:0]          disp_req, ret_req, deq, enq;
  logic                overflow;

  // Clamp requests, limit dequeue to occupancy, drop an enqueue that would overfill.
  always_comb begin
    disp_req = (rs_mt_fl_dispatch_num == 2'd3) ? 2'd2 : rs_mt_fl_dispatch_num;
    ret_req  = (fl_retire_num == 2'd3) ? 2'd2 : fl_retire_num;
    deq      = (FL_CNT_W'(disp_req) > count_q) ? count_q[1:0] : disp_req;
    overflow = (count_q - FL_CNT_W'(deq) + FL_CNT_W'(ret_req)) > FL_CNT_W'(FL_DEPTH);
    enq      = overflow ? 2'd0 : ret_req;
    count_d  = count_q - FL_CNT_W'(deq) + FL_CNT_W'(enq);
  end

  fl_ptr_inc u_head_nxt (.ptr_i(head_q), .inc_i(deq),  .ptr_o(head_d));
  fl_ptr_inc u_tail_nxt (.ptr_i(tail_q), .inc_i(enq),  .ptr_o(tail_d));
  fl_ptr_inc u_head_p1  (.ptr_i(head_q), .inc_i(2'd1), .ptr_o(head_p1));
  fl_ptr_inc u_tail_p1  (.ptr_i(tail_q), .inc_i(2'd1), .ptr_o(tail_p1));

  // Storage and pointers; reset image holds every non-architectural tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= PR_W'(AR_NUM + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (enq != 2'd0) mem_q[tail_q]  <= fl_retire_tag_a;
      if (enq == 2'd2) mem_q[tail_p1] <= fl_retire_tag_b;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Head tags are masked to 0 when not backed by a valid entry.
  always_comb begin
    fl_pr0   = (count_q >= FL_CNT_W'(1)) ? mem_q[head_q]  : '0;
    fl_pr1   = (count_q >= FL_CNT_W'(2)) ? mem_q[head_p1] : '0;
    fl_avail = (count_q >= FL_CNT_W'(2)) ? 2'd2 : count_q[1:0];
  end

`ifdef FL_CHECK_EN
  logic err_q;
  logic under_req, bad_num;

  // Raw (unclamped) request values are checked so an encoding of 3 is caught.
  always_comb begin
    under_req = FL_CNT_W'(rs_mt_fl_dispatch_num) > count_q;
    bad_num   = (rs_mt_fl_dispatch_num == 2'd3) || (fl_retire_num == 2'd3);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (under_req || overflow || bad_num) begin
      err_q <= 1'b1;
`ifndef SYNTHESIS
      $display("[free_list] t=%0t protocol error: under=%0b over=%0b bad_num=%0b",
               $time, under_req, overflow, bad_num);
`endif
    end
  end

  assign fl_err = err_q;
`else
  assign fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_free_list;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] fl_retire_tag_a, fl_retire_tag_b;
  logic [1:0] fl_retire_num, rs_mt_fl_dispatch_num;
  logic [6:0] fl_pr0, fl_pr1;
  logic [1:0] fl_avail;
  logic       fl_err;

  int tests = 0;
  int fails = 0;

  logic [6:0] q[$];
  logic       m_err;

  free_list dut (
    .clock                 (clock),
    .reset                 (reset),
    .fl_retire_tag_a       (fl_retire_tag_a),
    .fl_retire_tag_b       (fl_retire_tag_b),
    .fl_retire_num         (fl_retire_num),
    .rs_mt_fl_dispatch_num (rs_mt_fl_dispatch_num),
    .fl_pr0                (fl_pr0),
    .fl_pr1                (fl_pr1),
    .fl_avail              (fl_avail),
    .fl_err                (fl_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(7'(32 + i));
    m_err = 1'b0;
  endtask

  task automatic model_cycle(input logic [1:0] d, input logic [1:0] r,
                             input logic [6:0] ta, input logic [6:0] tb);
    int dq, eq, sz;
    sz = q.size();
    dq = (d == 3) ? 2 : int'(d);
    if (dq > sz) dq = sz;
    eq = (r == 3) ? 2 : int'(r);
    if (sz - dq + eq > 32) begin
`ifdef FL_CHECK_EN
      m_err = 1'b1;
`endif
      eq = 0;
    end
`ifdef FL_CHECK_EN
    if (int'(d) > sz || d == 3 || r == 3) m_err = 1'b1;
`endif
    for (int k = 0; k < dq; k++) void'(q.pop_front());
    if (eq >= 1) q.push_back(ta);
    if (eq == 2) q.push_back(tb);
  endtask

  task automatic check_model(input string tag);
    logic [6:0] e0, e1;
    logic [1:0] ea;
    e0 = (q.size() >= 1) ? q[0] : 7'd0;
    e1 = (q.size() >= 2) ? q[1] : 7'd0;
    ea = (q.size() >= 2) ? 2'd2 : 2'(q.size());
    chk({tag, ".pr0"},   8'(fl_pr0),   8'(e0));
    chk({tag, ".pr1"},   8'(fl_pr1),   8'(e1));
    chk({tag, ".avail"}, 8'(fl_avail), 8'(ea));
    chk({tag, ".err"},   8'(fl_err),   8'(m_err));
  endtask

  // Drive one cycle of inputs, clock it, update the model, then check #1 after the edge.
  task automatic step(input string tag, input logic [1:0] d, input logic [1:0] r,
                      input logic [6:0] ta, input logic [6:0] tb);
    rs_mt_fl_dispatch_num = d;
    fl_retire_num         = r;
    fl_retire_tag_a       = ta;
    fl_retire_tag_b       = tb;
    @(posedge clock);
    model_cycle(d, r, ta, tb);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset                 = 1'b1;
    rs_mt_fl_dispatch_num = 2'd0;
    fl_retire_num         = 2'd0;
    fl_retire_tag_a       = 7'd0;
    fl_retire_tag_b       = 7'd0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [1:0] d, r;
    logic [6:0] ta, tb;
    model_reset();

    // Reset image
    do_reset();
    check_model("reset");
    chk("reset.pr0_abs", 8'(fl_pr0), 8'd32);
    chk("reset.pr1_abs", 8'(fl_pr1), 8'd33);

    // Drain in pairs
    for (int i = 0; i < 16; i++) step("drain", 2'd2, 2'd0, 7'd0, 7'd0);
    chk("drain.avail_abs", 8'(fl_avail), 8'd0);
    chk("drain.pr0_abs",   8'(fl_pr0),   8'd0);

    // Dispatch on empty is ignored
    step("empty_disp", 2'd1, 2'd0, 7'd0, 7'd0);

    // Refill after tail wrap
    step("wrap_refill", 2'd0, 2'd2, 7'd4, 7'd5);
    chk("wrap.pr0_abs", 8'(fl_pr0), 8'd4);
    chk("wrap.pr1_abs", 8'(fl_pr1), 8'd5);

    // Simultaneous retire/dispatch at full
    do_reset();
    step("full_simul", 2'd2, 2'd2, 7'd6, 7'd7);
    chk("full.pr0_abs", 8'(fl_pr0), 8'd34);
    chk("full.pr1_abs", 8'(fl_pr1), 8'd35);
    for (int i = 0; i < 15; i++) step("full_drain", 2'd2, 2'd0, 7'd0, 7'd0);
    chk("full_end.pr0_abs", 8'(fl_pr0), 8'd6);
    chk("full_end.pr1_abs", 8'(fl_pr1), 8'd7);

    // Underflow: count 1 with head tag 9, dispatch 2
    do_reset();
    for (int i = 0; i < 16; i++) step("uf_drain", 2'd2, 2'd0, 7'd0, 7'd0);
    step("uf_fill", 2'd0, 2'd1, 7'd9, 7'd0);
    chk("uf.head9", 8'(fl_pr0), 8'd9);
    step("uf_disp2", 2'd2, 2'd0, 7'd0, 7'd0);
    chk("uf.avail_abs", 8'(fl_avail), 8'd0);

    // Overflow: retire at full without dispatch is dropped
    do_reset();
    step("of_drop", 2'd0, 2'd1, 7'd11, 7'd0);
    chk("of.pr0_abs", 8'(fl_pr0), 8'd32);

    // Random traffic with a mid-stream asynchronous reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      d  = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      r  = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      ta = 7'($urandom_range(0, 127));
      tb = 7'($urandom_range(0, 127));
      step("rand", d, r, ta, tb);
      if (i == 200) begin
        rs_mt_fl_dispatch_num = 2'd2;
        fl_retire_num         = 2'd2;
        reset = 1'b1;
        #2;
        model_reset();
        chk("async.pr0_abs",   8'(fl_pr0),   8'd32);
        chk("async.pr1_abs",   8'(fl_pr1),   8'd33);
        chk("async.avail_abs", 8'(fl_avail), 8'd2);
        @(posedge clock);
        #2;
        check_model("async_hold");
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
